// File: rtl/ctmm_ns_table.sv
// Namespace table: GC read/write port plus LOAD access port; 1-cycle read/ack latency, no backpressure.
// Zero-fills on reset, then raises init_done. Optional per-entry parity with CTMM_NS_PARITY_EN.
package ctmm_ns_pkg;
    typedef struct packed {
        logic [15:0] ns_id;
        logic [7:0]  gen;
        logic [7:0]  perms;
    } golden_token_t;
    localparam int PERM_G = 3;
endpackage

module ctmm_ns_table
    import ctmm_ns_pkg::*;
#(
    parameter logic [31:0] NS_BASE = 32'h0000_0000,
    parameter int          DEPTH   = 256,
    parameter int          IDX_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic [31:0]         ns_addr,
    input  logic                ns_rd_en,
    output golden_token_t       ns_rd_data,
    input  logic                ns_wr_en,
    input  golden_token_t       ns_wr_data,
    input  logic                ld_req,
    input  logic [31:0]         ld_addr,
    input  logic                ld_valid_key,
    output logic                ld_ack,
    output golden_token_t       ld_rdata,
    output logic                ld_err,
    output logic                g_clear_pulse,
    output logic [31:0]         g_clear_count
`ifdef CTMM_NS_PARITY_EN
    ,
    output logic                par_err
`endif
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IDX_W-1:0] fill_q, fill_d;
    golden_token_t   ns_rd_data_q, ns_rd_data_d;
    logic            ld_ack_q, ld_ack_d;
    golden_token_t   ld_rdata_q, ld_rdata_d;
    logic            ld_err_q, ld_err_d;
    logic            g_clear_pulse_q, g_clear_pulse_d;
    logic [31:0]     g_clear_count_q, g_clear_count_d;

    golden_token_t   mem_q [DEPTH];

    logic            ready;
    logic            ns_borrow, ld_borrow;
    logic [31:0]     ns_off, ld_off;
    logic            ns_in, ld_in;
    logic [IDX_W-1:0] ns_idx, ld_idx;
    golden_token_t   ns_ent, ld_ent;
    logic            g_clr, gc_wr, same_idx, clr_wr;
    golden_token_t   wr_dat, clr_dat;
    logic            ld_par_bad, ns_par_bad;

    // 33-bit subtract so the borrow flags addresses below NS_BASE
    always_comb begin
        {ns_borrow, ns_off} = {1'b0, ns_addr} - {1'b0, NS_BASE};
        {ld_borrow, ld_off} = {1'b0, ld_addr} - {1'b0, NS_BASE};
        ns_in  = !ns_borrow && (ns_off < 32'(DEPTH));
        ld_in  = !ld_borrow && (ld_off < 32'(DEPTH));
        ns_idx = ns_off[IDX_W-1:0];
        ld_idx = ld_off[IDX_W-1:0];
        ready  = (state_q == ST_READY);
        ns_ent = mem_q[ns_idx];
        ld_ent = mem_q[ld_idx];
    end

`ifdef CTMM_NS_PARITY_EN
    logic par_q [DEPTH];
    logic par_err_q, par_err_d;

    always_comb begin
        ns_par_bad = (^ns_ent) != par_q[ns_idx];
        ld_par_bad = (^ld_ent) != par_q[ld_idx];
        par_err_d  = par_err_q
                   | (ns_rd_en && ready && ns_in && ns_par_bad)
                   | (ld_req && ready && ld_in && ld_par_bad);
    end

    assign par_err = par_err_q;
`else
    always_comb begin
        ns_par_bad = 1'b0;
        ld_par_bad = 1'b0;
    end
`endif

    always_comb begin
        g_clr    = ld_req && ld_valid_key && ld_in && ready && ld_ent.perms[PERM_G];
        gc_wr    = ns_wr_en && ns_in && ready;
        same_idx = (ns_idx == ld_idx);
        // A LOAD after the mark wins over a GC write: entry stays reachable (G=0)
        wr_dat   = ns_wr_data;
        if (g_clr && same_idx) begin
            wr_dat.perms[PERM_G] = 1'b0;
        end
        clr_dat  = ld_ent;
        clr_dat.perms[PERM_G] = 1'b0;
        clr_wr   = g_clr && !(gc_wr && same_idx);
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (state_q == ST_INIT) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end

        ns_rd_data_d = ns_rd_data_q;
        if (ns_rd_en) begin
            ns_rd_data_d = (ready && ns_in) ? ns_ent : '0;
        end

        ld_ack_d        = ld_req;
        ld_err_d        = ld_req && (!(ld_in && ready) || ld_par_bad);
        ld_rdata_d      = (ld_req && ld_in && ready) ? ld_ent : '0;
        g_clear_pulse_d = g_clr;
        g_clear_count_d = g_clear_count_q;
        if (g_clr && (g_clear_count_q != 32'hFFFF_FFFF)) begin
            g_clear_count_d = g_clear_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_INIT;
            fill_q          <= '0;
            ns_rd_data_q    <= '0;
            ld_ack_q        <= 1'b0;
            ld_rdata_q      <= '0;
            ld_err_q        <= 1'b0;
            g_clear_pulse_q <= 1'b0;
            g_clear_count_q <= '0;
`ifdef CTMM_NS_PARITY_EN
            par_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            fill_q          <= fill_d;
            ns_rd_data_q    <= ns_rd_data_d;
            ld_ack_q        <= ld_ack_d;
            ld_rdata_q      <= ld_rdata_d;
            ld_err_q        <= ld_err_d;
            g_clear_pulse_q <= g_clear_pulse_d;
            g_clear_count_q <= g_clear_count_d;
`ifdef CTMM_NS_PARITY_EN
            par_err_q       <= par_err_d;
`endif
        end
    end

    // Storage is not reset; the INIT sweep zero-fills it
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[fill_q] <= '0;
        end else begin
            if (gc_wr) begin
                mem_q[ns_idx] <= wr_dat;
            end
            if (clr_wr) begin
                mem_q[ld_idx] <= clr_dat;
            end
        end
    end

`ifdef CTMM_NS_PARITY_EN
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            par_q[fill_q] <= 1'b0;
        end else begin
            if (gc_wr) begin
                par_q[ns_idx] <= ^wr_dat;
            end
            if (clr_wr) begin
                par_q[ld_idx] <= ^clr_dat;
            end
        end
    end
`endif

    assign init_done     = (state_q == ST_READY);
    assign ns_rd_data    = ns_rd_data_q;
    assign ld_ack        = ld_ack_q;
    assign ld_rdata      = ld_rdata_q;
    assign ld_err        = ld_err_q;
    assign g_clear_pulse = g_clear_pulse_q;
    assign g_clear_count = g_clear_count_q;

endmodule

// File: tb/tb_ctmm_ns_table.sv
// Scoreboard bench for ctmm_ns_table: directed GC/LOAD vectors, expectations queued at issue time.
module tb_ctmm_ns_table;
    import ctmm_ns_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic [31:0]   ns_addr;
    logic          ns_rd_en;
    golden_token_t ns_rd_data;
    logic          ns_wr_en;
    golden_token_t ns_wr_data;
    logic          ld_req;
    logic [31:0]   ld_addr;
    logic          ld_valid_key;
    logic          ld_ack;
    golden_token_t ld_rdata;
    logic          ld_err;
    logic          g_clear_pulse;
    logic [31:0]   g_clear_count;
`ifdef CTMM_NS_PARITY_EN
    logic          par_err;
`endif

    ctmm_ns_table dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .ns_addr(ns_addr), .ns_rd_en(ns_rd_en), .ns_rd_data(ns_rd_data),
        .ns_wr_en(ns_wr_en), .ns_wr_data(ns_wr_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_valid_key(ld_valid_key),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .g_clear_pulse(g_clear_pulse), .g_clear_count(g_clear_count)
`ifdef CTMM_NS_PARITY_EN
        , .par_err(par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          err;
        golden_token_t rdata;
        logic          pulse;
        logic [31:0]   cnt;
    } ld_exp_t;

    localparam logic [31:0] NSB = 32'h0000_0000;
    // Tokens with G (perms bit 3) set, and their G-cleared forms
    localparam golden_token_t TA  = 32'h1234_560F;
    localparam golden_token_t TAC = 32'h1234_5607;
    localparam golden_token_t TB  = 32'hBEEF_0108;
    localparam golden_token_t TC  = 32'hC0DE_02FF;
    localparam golden_token_t TCC = 32'hC0DE_02F7;
    localparam golden_token_t TD  = 32'hD00D_0308;
    localparam golden_token_t TE  = 32'hE1E1_0409;
    localparam golden_token_t TEC = 32'hE1E1_0401;
    localparam golden_token_t TF  = 32'hF00F_05AA;
    localparam golden_token_t TT  = 32'h5555_FF08;
    localparam golden_token_t TTC = 32'h5555_FF00;
    localparam golden_token_t TZ  = 32'h0000_0000;

    golden_token_t gc_q [$];
    ld_exp_t       ld_q [$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic          rd_seen;
    golden_token_t ge;
    ld_exp_t       le;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ns_rd_en     = 1'b0;
        ns_wr_en     = 1'b0;
        ld_req       = 1'b0;
        ld_valid_key = 1'b0;
    endtask

    task automatic set_rd(input logic [31:0] a, input golden_token_t e);
        ns_addr  = a;
        ns_rd_en = 1'b1;
        gc_q.push_back(e);
    endtask

    task automatic set_wr(input logic [31:0] a, input golden_token_t d);
        ns_addr    = a;
        ns_wr_en   = 1'b1;
        ns_wr_data = d;
    endtask

    task automatic set_ld(input logic [31:0] a, input logic key, input logic err,
                          input golden_token_t rd, input logic pulse, input logic [31:0] cnt);
        ld_exp_t x;
        ld_addr      = a;
        ld_req       = 1'b1;
        ld_valid_key = key;
        x.err = err; x.rdata = rd; x.pulse = pulse; x.cnt = cnt;
        ld_q.push_back(x);
    endtask

    // Counts posedges after rst release until init_done; drops one-shot requests after the first edge
    task automatic wait_init(input string name);
        int c;
        c = 0;
        while (!init_done && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
            ns_rd_en     = 1'b0;
            ns_wr_en     = 1'b0;
            ld_req       = 1'b0;
            ld_valid_key = 1'b0;
        end
        chk(name, 80'(c), 80'd256);
    endtask

    initial begin
        rst = 1'b1;
        ns_addr = '0; ns_rd_en = 1'b0; ns_wr_en = 1'b0; ns_wr_data = '0;
        ld_req = 1'b0; ld_addr = '0; ld_valid_key = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(posedge clk);
                    rd_seen = ns_rd_en;
                    #1;
                    if (rd_seen) begin
                        if (gc_q.size() == 0) begin
                            chk("gc_rd_unexpected", 80'd1, 80'd0);
                        end else begin
                            ge = gc_q.pop_front();
                            chk("gc_rd_data", 80'(ns_rd_data), 80'(ge));
                        end
                    end
                    if (ld_ack) begin
                        if (ld_q.size() == 0) begin
                            chk("ld_ack_unexpected", 80'd1, 80'd0);
                        end else begin
                            le = ld_q.pop_front();
                            chk("ld_resp", 80'({ld_err, ld_rdata, g_clear_pulse, g_clear_count}),
                                80'({le.err, le.rdata, le.pulse, le.cnt}));
                        end
                    end
                end
            end
            begin : stimulus
                @(negedge clk);
                chk("reset_outputs", 80'({init_done, ns_rd_data, ld_ack, ld_rdata, ld_err,
                                          g_clear_pulse, g_clear_count}), 80'd0);
                @(negedge clk);
                rst = 1'b0;
                wait_init("init_cycles");
                tick();

                set_rd(NSB + 32'd5, TZ);                      tick();
                set_wr(NSB + 32'd3, TA);                      tick();
                set_rd(NSB + 32'd3, TA);                      tick();
                set_ld(NSB + 32'd3, 1'b1, 1'b0, TA, 1'b1, 32'd1); tick();
                set_rd(NSB + 32'd3, TAC);                     tick();
                set_ld(NSB + 32'd3, 1'b1, 1'b0, TAC, 1'b0, 32'd1); tick();
                set_wr(NSB + 32'd4, TB);                      tick();
                set_ld(NSB + 32'd4, 1'b0, 1'b0, TB, 1'b0, 32'd1); tick();

                // collision: GC write and G clear hit entry 7 together
                set_wr(NSB + 32'd7, TD);                      tick();
                set_wr(NSB + 32'd7, TC);
                set_ld(NSB + 32'd7, 1'b1, 1'b0, TD, 1'b1, 32'd2); tick();
                set_rd(NSB + 32'd7, TCC);                     tick();

                set_wr(NSB + 32'd4, TE);
                set_rd(NSB + 32'd4, TB);                      tick();
                set_rd(NSB + 32'd4, TE);                      tick();

                set_wr(NSB + 32'd8, TF);
                set_ld(NSB + 32'd4, 1'b1, 1'b0, TE, 1'b1, 32'd3); tick();
                set_rd(NSB + 32'd8, TF);                      tick();
                set_rd(NSB + 32'd4, TEC);                     tick();

                set_ld(NSB + 32'd256, 1'b1, 1'b1, TZ, 1'b0, 32'd3); tick();
                set_ld(32'hFFFF_FFFF, 1'b1, 1'b1, TZ, 1'b0, 32'd3); tick();
                set_wr(NSB + 32'd300, TF);                    tick();
                set_rd(NSB + 32'd300, TZ);                    tick();
                set_rd(NSB + 32'd44, TZ);                     tick();

                set_wr(NSB + 32'd255, TT);                    tick();
                set_ld(NSB + 32'd255, 1'b1, 1'b0, TT, 1'b1, 32'd4); tick();
                set_rd(NSB + 32'd255, TTC);                   tick();
                tick();
                tick();
                chk("rd_data_hold", 80'(ns_rd_data), 80'(TTC));

                // reset in the middle of the fill
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (100) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                #1;
                chk("midfill_reset", 80'({init_done, ld_ack, g_clear_pulse, g_clear_count}), 80'd0);
                @(negedge clk);
                rst = 1'b0;
                set_ld(NSB + 32'd2, 1'b1, 1'b1, TZ, 1'b0, 32'd0);
                set_rd(NSB + 32'd3, TZ);
                wait_init("init_cycles_after_midfill");
                tick();
                set_rd(NSB + 32'd3, TZ);                      tick();
                set_rd(NSB + 32'd255, TZ);                    tick();

`ifdef CTMM_NS_PARITY_EN
                set_wr(NSB + 32'd9, 32'h9999_0001);           tick();
                dut.par_q[9] = ~dut.par_q[9];
                set_ld(NSB + 32'd9, 1'b1, 1'b1, 32'h9999_0001, 1'b0, 32'd0); tick();
                set_rd(NSB + 32'd9, 32'h9999_0001);           tick();
                tick();
                chk("par_err_sticky", 80'(par_err), 80'd1);
`endif
                tick();
                tick();
                chk("scoreboard_drain", 80'(gc_q.size() + ld_q.size()), 80'd0);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ctmm_ns_table.md
Name: ctmm_ns_table

Overview:
- Namespace table memory: the responder for the GC unit's namespace read/write port and for the LOAD path's access port.
- Stores golden tokens and serves GC mark/sweep reads and writes with fixed 1-cycle read latency.
- On a valid-key LOAD access, clears the entry's G bit in place.
- Zero-fills itself after reset and raises init_done when ready.

Parameters:
- NS_BASE, 32'h0000_0000, first namespace address served.
- DEPTH, 256, number of entries (power of two, 2..65536).
- IDX_W, $clog2(DEPTH), index width (derived).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- init_done  output  1  high once zero-fill is complete
- ns_addr  input  32  GC port address
- ns_rd_en  input  1  GC read request
- ns_rd_data  output  golden_token_t  GC read data, registered
- ns_wr_en  input  1  GC write request
- ns_wr_data  input  golden_token_t  GC write data
- ld_req  input  1  LOAD-path access request
- ld_addr  input  32  LOAD-path address
- ld_valid_key  input  1  access made with a valid key (qualifies G clear)
- ld_ack  output  1  one-cycle response strobe
- ld_rdata  output  golden_token_t  LOAD read data
- ld_err  output  1  out-of-range or not-ready access, valid with ld_ack
- g_clear_pulse  output  1  a G bit was cleared this cycle
- g_clear_count  output  32  saturating count of G clears since reset

Behaviour:
- Reset (async, rst=1): every output is 0, the FSM enters INIT, the fill index is 0. Memory contents are not reset; the INIT sweep clears them.
- FSM states: INIT and READY.
  - INIT: writes all-zero to entry[fill_idx] each cycle and increments fill_idx.
  - After entry DEPTH-1 is written, moves to READY next cycle. init_done=1 from the first READY cycle.
  - INIT takes exactly DEPTH cycles.
- Reset asserted mid-operation returns the block to INIT and restarts the fill from index 0.
- Address decode:
  - in_range = addr >= NS_BASE && addr - NS_BASE < DEPTH.
  - idx = (addr - NS_BASE)[IDX_W-1:0].
- GC read: ns_rd_en in cycle N, with READY and in range, puts entry[idx] on ns_rd_data in cycle N+1. Out-of-range or INIT gives all-zero. ns_rd_data holds its value until the next ns_rd_en.
- GC write: ns_wr_en with READY and in range writes ns_wr_data at the clock edge. Out-of-range or INIT writes are dropped silently.
- Same-cycle GC read and write to the same index: the read returns the old contents.
- LOAD access: ld_req in cycle N gives ld_ack=1 in N+1.
  - ld_rdata is the entry value before any clear.
  - ld_err=1 if out of range or not READY; in that case ld_rdata=0 and nothing is modified.
- G clear:
  - Condition: ld_req && ld_valid_key && in_range && READY && entry[idx].perms[PERM_G]==1.
  - Action: clears perms[PERM_G] at the edge; g_clear_pulse=1 in N+1; g_clear_count increments, saturating at 32'hFFFF_FFFF.
  - With ld_valid_key=0, or G already 0: no modification and no pulse.
- Collision (GC write and LOAD clear to the same index, same cycle): the stored value is ns_wr_data with perms[PERM_G] forced to 0. The access happened after the mark, so the entry counts as reachable. g_clear_pulse still fires.
- GC write and LOAD clear to different indices in the same cycle: both take effect.
- No backpressure: every request is serviced in a single cycle.

Optional Feature:
- CTMM_NS_PARITY_EN, when defined:
  - Each entry stores an even-parity bit over the token, computed on every write (INIT zero-fill, GC write, G clear).
  - On a GC read, a parity mismatch sets sticky output par_err (1 bit, cleared only by rst); on a LOAD read it also forces ld_err=1.
- When not defined: no parity storage, and par_err is absent from the port list.

Test Plan:
- Reset, then count cycles to init_done → init_done rises exactly DEPTH (256) cycles after rst deasserts. A GC read of NS_BASE+5 then returns all-zero.
- GC write NS_BASE+3 with G=1, then ns_rd_en at NS_BASE+3 → ns_rd_data matches the written token 1 cycle later.
- ld_req NS_BASE+3 with ld_valid_key=1 → ld_ack=1, ld_rdata shows G=1, g_clear_pulse=1, g_clear_count=1. A following GC read shows G=0.
- Same-cycle GC write NS_BASE+7 (G=1) and valid-key ld_req NS_BASE+7 → the stored entry has G=0.
- ld_req at NS_BASE+256 → ld_ack=1, ld_err=1, ld_rdata=0. A GC write at NS_BASE+300 leaves all entries unchanged.
- rst pulsed at fill_idx=100 → init_done=0, and the fill restarts taking a full 256 cycles. With CTMM_NS_PARITY_EN, force an entry bit flip and read it → par_err=1.
